// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the ALU and its multiply/divide
//               sequencer: ALU opcodes, MUL/DIVU request encoding and the
//               sequencer state encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // ALU opcodes as decoded by the shared combinational ALU.
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;  // unsigned compare, result in bit 0
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // Request type carried on op_i.
  typedef enum logic {
    OP_MUL  = 1'b0,
    OP_DIVU = 1'b1
  } md_op_e;

  // Sequencer states.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MUL     = 3'd1,
    S_DIV_CMP = 3'd2,
    S_DIV_SUB = 3'd3,
    S_DONE    = 3'd4
  } md_state_e;

endpackage
`default_nettype wire

// File: rtl/alu_seq_cnt.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_cnt
// Description : Iteration counter for the multiply/divide sequencer.
//               Synchronous clear has priority over enable; last flags the
//               final iteration (count == LAST).
// Ports       : clk   - clock, rising edge
//               rst_n - synchronous active-low reset
//               clr   - clear count to zero
//               en    - increment count
//               last  - count equals LAST
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_cnt #(
  parameter int CNT_W = 6,
  parameter int LAST  = 31
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign last = (cnt == LAST_CNT);

endmodule
`default_nettype wire

// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_muldiv_seq
// Description : Multi-cycle sequencer that borrows the shared combinational
//               ALU to perform unsigned 32-bit multiply (low word, shift-add)
//               and unsigned divide (restoring, two ALU cycles per bit).
// Ports       : clk_i, rst_ni        - clock / synchronous active-low reset
//               start_i, op_i        - request strobe, 0=MUL 1=DIVU
//               src_a_i, src_b_i     - multiplicand/dividend, multiplier/divisor
//               busy_o, done_o       - busy window / one-cycle completion pulse
//               res_o, rem_o         - product or quotient / remainder
//               div_zero_o           - DIVU with zero divisor
//               alu_a_o, alu_b_o,
//               alu_op_o, alu_res_i  - ALU operand/opcode drive and result
// Revision    : 1.0 - initial release
// ============================================================================
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            op_i,
  input  logic [XLEN-1:0] src_a_i,
  input  logic [XLEN-1:0] src_b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] res_o,
  output logic [XLEN-1:0] rem_o,
  output logic            div_zero_o,
  output logic [XLEN-1:0] alu_a_o,
  output logic [XLEN-1:0] alu_b_o,
  output logic [3:0]      alu_op_o,
  input  logic [XLEN-1:0] alu_res_i
);

  md_state_e       state;

  // Working registers are shared between the two operations:
  //   work_acc : MUL accumulator      / DIVU partial remainder
  //   work_a   : MUL multiplier (>>1) / DIVU quotient (dividend shifts out MSB-first)
  //   work_b   : MUL multiplicand(<<1)/ DIVU divisor (static)
  logic [XLEN-1:0] work_acc;
  logic [XLEN-1:0] work_a;
  logic [XLEN-1:0] work_b;
  logic            carry;   // bit shifted out of the remainder in DIV_CMP
  logic            lt;      // shifted remainder < divisor (from SLT)

  logic            accept;
  logic            cnt_en;
  logic            cnt_last;
  logic [XLEN-1:0] div_sh;
  logic            div_take;

  assign accept = (state == S_IDLE) && start_i;
  assign cnt_en = (state == S_MUL) || (state == S_DIV_SUB);

  // Remainder shifted left with the next dividend bit brought in.
  assign div_sh = {work_acc[XLEN-2:0], work_a[XLEN-1]};

  // A set carry means the true shifted remainder is >= 2^XLEN and therefore
  // >= divisor; the XLEN-bit SUB result then wraps to the exact value.
  assign div_take = carry | ~lt;

  alu_seq_cnt #(
    .CNT_W (CNT_W),
    .LAST  (XLEN - 1)
  ) u_cnt (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .clr   (accept),
    .en    (cnt_en),
    .last  (cnt_last)
  );

  // ALU drive is decoded from registered state so the result returns in the
  // same cycle; outside the arithmetic states the ALU inputs are parked at 0.
  always_comb begin
    alu_a_o  = '0;
    alu_b_o  = '0;
    alu_op_o = ALU_AND;
    case (state)
      S_MUL: begin
        alu_op_o = ALU_ADD;
        alu_a_o  = work_acc;
        alu_b_o  = work_a[0] ? work_b : '0;
      end
      S_DIV_CMP: begin
        alu_op_o = ALU_SLT;
        alu_a_o  = div_sh;
        alu_b_o  = work_b;
      end
      S_DIV_SUB: begin
        alu_op_o = ALU_SUB;
        alu_a_o  = work_acc;
        alu_b_o  = work_b;
      end
      default: begin
        alu_op_o = ALU_AND;
      end
    endcase
  end

  // Results are loaded on the edge that enters DONE so they are valid in the
  // same cycle that done_o pulses.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state      <= S_IDLE;
      work_acc   <= '0;
      work_a     <= '0;
      work_b     <= '0;
      carry      <= 1'b0;
      lt         <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      res_o      <= '0;
      rem_o      <= '0;
      div_zero_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            busy_o     <= 1'b1;
            res_o      <= '0;
            rem_o      <= '0;
            div_zero_o <= 1'b0;
            work_acc   <= '0;
            carry      <= 1'b0;
            lt         <= 1'b0;
            if (op_i == OP_MUL) begin
              work_a <= src_b_i;
              work_b <= src_a_i;
              state  <= S_MUL;
            end else if (src_b_i == '0) begin
              // Divide by zero completes immediately without the ALU.
              work_a     <= src_a_i;
              work_b     <= '0;
              res_o      <= '1;
              rem_o      <= src_a_i;
              div_zero_o <= 1'b1;
              done_o     <= 1'b1;
              state      <= S_DONE;
            end else begin
              work_a <= src_a_i;
              work_b <= src_b_i;
              state  <= S_DIV_CMP;
            end
          end
        end

        S_MUL: begin
          work_acc <= alu_res_i;
          work_b   <= work_b << 1;
          work_a   <= work_a >> 1;
          if (cnt_last) begin
            res_o  <= alu_res_i;
            done_o <= 1'b1;
            state  <= S_DONE;
          end
        end

        S_DIV_CMP: begin
          carry    <= work_acc[XLEN-1];
          work_acc <= div_sh;
          lt       <= alu_res_i[0];
          work_a   <= {work_a[XLEN-2:0], 1'b0};
          state    <= S_DIV_SUB;
        end

        S_DIV_SUB: begin
          if (div_take) begin
            work_acc  <= alu_res_i;
            work_a[0] <= 1'b1;
          end
          if (cnt_last) begin
            res_o  <= {work_a[XLEN-1:1], div_take};
            rem_o  <= div_take ? alu_res_i : work_acc;
            done_o <= 1'b1;
            state  <= S_DONE;
          end else begin
            state  <= S_DIV_CMP;
          end
        end

        S_DONE: begin
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end

        default: begin
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_muldiv_seq
// Description : Self-checking bench for alu_muldiv_seq. A small behavioural
//               ALU closes the loop; a scoreboard queue holds expected
//               results and a negedge monitor compares them on done_o.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        op;
  logic [31:0] src_a, src_b;
  logic        busy, done, div_zero;
  logic [31:0] res, rem, alu_a, alu_b, alu_res;
  logic [3:0]  alu_op;

  always #5 clk = ~clk;

  alu_muldiv_seq #(.XLEN(32), .CNT_W(6)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .op_i       (op),
    .src_a_i    (src_a),
    .src_b_i    (src_b),
    .busy_o     (busy),
    .done_o     (done),
    .res_o      (res),
    .rem_o      (rem),
    .div_zero_o (div_zero),
    .alu_a_o    (alu_a),
    .alu_b_o    (alu_b),
    .alu_op_o   (alu_op),
    .alu_res_i  (alu_res)
  );

  // Behavioural stand-in for the shared ALU.
  always_comb begin
    alu_res = 32'h0;
    case (alu_op)
      4'b0000: alu_res = alu_a & alu_b;
      4'b0001: alu_res = alu_a | alu_b;
      4'b0010: alu_res = alu_a + alu_b;
      4'b0110: alu_res = alu_a - alu_b;
      4'b0111: alu_res = {31'h0, (alu_a < alu_b)};
      4'b1100: alu_res = ~(alu_a | alu_b);
      default: alu_res = 32'h0;
    endcase
  end

  typedef struct {
    logic [31:0] res;
    logic [31:0] rem;
    logic        dz;
    bit          div0;
    int          push_cyc;
    int          done_at;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b0;
  bit          in_reset = 1'b1;
  logic [31:0] last_res = 32'h0;
  logic [31:0] last_rem = 32'h0;
  logic        last_dz = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain arithmetic on the operands plus the documented latency.
  function automatic exp_t model(input logic o, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    e.div0 = 1'b0;
    e.dz   = 1'b0;
    e.push_cyc = 0;
    if (o == 1'b0) begin
      p       = {32'h0, a} * {32'h0, b};
      e.res   = p[31:0];
      e.rem   = 32'h0;
      e.done_at = 33;
    end else if (b == 32'h0) begin
      e.res   = 32'hFFFF_FFFF;
      e.rem   = a;
      e.dz    = 1'b1;
      e.div0  = 1'b1;
      e.done_at = 1;
    end else begin
      e.res   = a / b;
      e.rem   = a % b;
      e.done_at = 65;
    end
    return e;
  endfunction

  // Monitor: compares on done_o, and checks busy / idle / held outputs otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && !in_reset) begin
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", {31'h0, done}, 32'h0);
        end else begin
          e = sb.pop_front();
          check("done_latency", cyc, e.done_at);
          check("res", res, e.res);
          check("rem", rem, e.rem);
          check("div_zero", {31'h0, div_zero}, {31'h0, e.dz});
          check("busy_in_done", {31'h0, busy}, 32'h1);
          last_res = e.res;
          last_rem = e.rem;
          last_dz  = e.dz;
        end
      end else if (sb.size() == 0) begin
        check("idle_busy", {31'h0, busy}, 32'h0);
        check("idle_alu_op", {28'h0, alu_op}, 32'h0);
        check("idle_alu_ab", alu_a | alu_b, 32'h0);
        check("held_res", res, last_res);
        check("held_rem", rem, last_rem);
        check("held_div_zero", {31'h0, div_zero}, {31'h0, last_dz});
      end else if (cyc > sb[0].done_at) begin
        check("missing_done", {31'h0, done}, 32'h1);
        e = sb.pop_front();
      end else if (cyc > sb[0].push_cyc) begin
        check("busy_active", {31'h0, busy}, 32'h1);
        check("results_cleared", res | rem | {31'h0, div_zero}, 32'h0);
        if (sb[0].div0) check("div0_alu_op", {28'h0, alu_op}, 32'h0);
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (busy) check("wait_idle_timeout", {31'h0, busy}, 32'h0);
  endtask

  task automatic issue(input logic o, input logic [31:0] a, input logic [31:0] b, input bit hold);
    exp_t e;
    int   k;
    wait_idle();
    e = model(o, a, b);
    e.push_cyc = cyc;
    e.done_at  = cyc + e.done_at;
    sb.push_back(e);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    @(negedge clk);
    if (hold) begin
      k = 0;
      while (!done && k < 100) begin
        @(negedge clk);
        k++;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_res"}, res, 32'h0);
    check({tag, "_rem"}, rem, 32'h0);
    check({tag, "_flags"}, {28'h0, busy, done, div_zero, 1'b0}, 32'h0);
    check({tag, "_alu_ab"}, alu_a | alu_b, 32'h0);
    check({tag, "_alu_op"}, {28'h0, alu_op}, 32'h0);
  endtask

  initial begin
    logic [31:0] a, b;
    logic        o;
    int          sel;
    rst_n = 1'b0;
    start = 1'b0;
    op    = 1'b0;
    src_a = 32'h0;
    src_b = 32'h0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    in_reset = 1'b0;
    mon_en   = 1'b1;

    // Directed cases.
    issue(1'b0, 32'd6, 32'd7, 1'b0);
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    issue(1'b0, 32'h0001_0000, 32'h0001_0000, 1'b0);
    issue(1'b1, 32'd100, 32'd7, 1'b0);
    issue(1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0);
    issue(1'b1, 32'd5, 32'd0, 1'b0);
    issue(1'b1, 32'h1234_5678, 32'd1, 1'b0);
    issue(1'b1, 32'd3, 32'hFFFF_FFFF, 1'b0);
    issue(1'b0, 32'h8000_0000, 32'd2, 1'b0);

    // start held high for the whole MUL: only one completion expected.
    issue(1'b0, 32'd11, 32'd13, 1'b1);

    // Reset in the middle of a divide aborts it silently.
    issue(1'b1, 32'd1000, 32'd9, 1'b0);
    repeat (8) @(negedge clk);
    in_reset = 1'b1;
    rst_n    = 1'b0;
    @(negedge clk);
    check_all_zero("midop_reset");
    sb.delete();
    last_res = 32'h0;
    last_rem = 32'h0;
    last_dz  = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    in_reset = 1'b0;

    issue(1'b0, 32'd3, 32'd3, 1'b0);

    // Randomised mix, with back-to-back and gapped issues.
    for (int i = 0; i < 40; i++) begin
      o   = 1'($urandom_range(0, 1));
      a   = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0:       b = 32'h0;
        1, 2:    b = 32'($urandom_range(1, 255));
        3:       b = 32'h8000_0000 | $urandom;
        default: b = $urandom;
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(o, a, b, 1'b0);
    end

    wait_idle();
    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
